crd_lane_sched: RTL and testbench

Time-multiplexed running-disparity (RD) checker for a multi-lane PCIe Gen1/Gen2 receive path. It arbitrates one 10-bit symbol per cycle, round-robin, from up to NUM_LANES lanes. It keeps per-lane RD state, flags disparity errors, counts them per lane, and fails a lane after a run of consecutive errors. It sits between the per-lane symbol aligners and the lane-deskew/LTSSM logic, and replaces one disparity checker per lane with one shared datapath.

---
 rtl/crd_lane_sched.sv | 154 +++++++++++++++
 tb/tb_crd_lane_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crd_lane_sched.sv
// crd_lane_sched: one shared running-disparity checker time-multiplexed round-robin over
// NUM_LANES receive lanes, with per-lane RD state, error counters and FAIL latching.
module crd_lane_sched #(
  parameter int NUM_LANES  = 4,
  parameter int iWIDTH     = 10,
  parameter int ERR_THRESH = 4,
  parameter int CNT_WIDTH  = 8,
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_LANES-1:0]        lane_valid,
  input  logic [NUM_LANES*iWIDTH-1:0] lane_data,
  output logic [NUM_LANES-1:0]        lane_ready,
  input  logic [NUM_LANES-1:0]        lane_clr,
  output logic                        chk_valid,
  output logic [LW-1:0]               chk_lane,
  output logic                        chk_err,
  output logic                        crd_bit,
  output logic [NUM_LANES-1:0]        lane_fail,
  input  logic [LW-1:0]               err_cnt_sel,
  output logic [CNT_WIDTH-1:0]        err_cnt
);
  localparam int HALF = iWIDTH / 2;

  typedef enum logic [1:0] {RD_IDLE, RD_NEG, RD_POS} rd_e;

  rd_e                  rd_q     [NUM_LANES];
  logic [3:0]           streak_q [NUM_LANES];
  logic [CNT_WIDTH-1:0] cnt_q    [NUM_LANES];
  logic [LW-1:0]        rr_ptr;

  logic                 s1_valid;
  logic [LW-1:0]        s1_lane;
  logic [iWIDTH-1:0]    s1_data;

  logic                 grant;
  logic [LW-1:0]        grant_idx;
  logic [LW-1:0]        scan_idx;
  logic [LW-1:0]        rr_next;

  int                   ones;
  rd_e                  cur_rd;
  rd_e                  rd_n;
  logic                 err_n;
  logic [3:0]           streak_n;
  logic                 fail_n;
  logic                 do_chk;

  // Scan from rr_ptr; failed lanes are never eligible.
  always_comb begin
    grant      = 1'b0;
    grant_idx  = '0;
    scan_idx   = '0;
    lane_ready = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      scan_idx = LW'((int'(rr_ptr) + k) % NUM_LANES);
      if (!grant && lane_valid[scan_idx] && !lane_fail[scan_idx]) begin
        grant     = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (grant) begin
      lane_ready[grant_idx] = 1'b1;
    end
    rr_next = (grant_idx == LW'(NUM_LANES - 1)) ? '0 : grant_idx + LW'(1);
  end

  always_comb begin
    ones   = $countones(s1_data);
    cur_rd = rd_q[s1_lane];
    rd_n   = cur_rd;
    err_n  = 1'b0;
    case (cur_rd)
      RD_POS: begin
        rd_n  = (ones < HALF) ? RD_NEG : RD_POS;
        err_n = (ones > HALF);
      end
      RD_NEG: begin
        rd_n  = (ones > HALF) ? RD_POS : RD_NEG;
        err_n = (ones < HALF);
      end
      default: rd_n = (ones >= HALF) ? RD_POS : RD_NEG;
    endcase
    streak_n = streak_q[s1_lane] + 4'd1;
    fail_n   = err_n && (streak_n >= 4'(ERR_THRESH));
    do_chk   = s1_valid && !lane_clr[s1_lane];
  end

  always_comb begin
    err_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (err_cnt_sel == LW'(i)) begin
        err_cnt = cnt_q[i];
      end
    end
  end

  // A lane clear is applied last so it overrides a same-edge check update of that lane.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= '0;
      s1_valid  <= 1'b0;
      s1_lane   <= '0;
      s1_data   <= '0;
      chk_valid <= 1'b0;
      chk_lane  <= '0;
      chk_err   <= 1'b0;
      crd_bit   <= 1'b0;
      lane_fail <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        rd_q[i]     <= RD_IDLE;
        streak_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      s1_valid <= grant;
      if (grant) begin
        s1_lane <= grant_idx;
        s1_data <= lane_data[grant_idx*iWIDTH +: iWIDTH];
        rr_ptr  <= rr_next;
      end

      chk_valid <= do_chk;
      if (do_chk) begin
        chk_lane       <= s1_lane;
        chk_err        <= err_n;
        crd_bit        <= (rd_n == RD_POS);
        rd_q[s1_lane]  <= fail_n ? RD_IDLE : rd_n;
        if (err_n) begin
          streak_q[s1_lane] <= streak_n;
          if (cnt_q[s1_lane] != '1) begin
            cnt_q[s1_lane] <= cnt_q[s1_lane] + CNT_WIDTH'(1);
          end
          if (fail_n) begin
            lane_fail[s1_lane] <= 1'b1;
          end
        end else begin
          streak_q[s1_lane] <= '0;
        end
      end

      for (int i = 0; i < NUM_LANES; i++) begin
        if (lane_clr[i]) begin
          rd_q[i]      <= RD_IDLE;
          streak_q[i]  <= '0;
          cnt_q[i]     <= '0;
          lane_fail[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_crd_lane_sched.sv
// tb_crd_lane_sched: directed and random stimulus for crd_lane_sched, compared cycle by
// cycle with a lane-level disparity model; a second instance covers counter saturation.
module tb_crd_lane_sched;
  localparam int N      = 4;
  localparam int W      = 10;
  localparam int THRESH = 4;
  localparam int CW     = 8;

  typedef logic [1:0] lidx_t;

  logic           clk;
  logic           rst;
  logic [N-1:0]   lane_valid;
  logic [N*W-1:0] lane_data;
  logic [N-1:0]   lane_ready;
  logic [N-1:0]   lane_clr;
  logic           chk_valid;
  lidx_t          chk_lane;
  logic           chk_err;
  logic           crd_bit;
  logic [N-1:0]   lane_fail;
  lidx_t          err_cnt_sel;
  logic [CW-1:0]  err_cnt;

  logic [N-1:0]   s_valid;
  logic [N*W-1:0] s_data;
  logic [N-1:0]   s_ready;
  logic [N-1:0]   s_clr;
  logic           s_chk_valid;
  lidx_t          s_chk_lane;
  logic           s_chk_err;
  logic           s_crd;
  logic [N-1:0]   s_fail;
  lidx_t          s_sel;
  logic [1:0]     s_cnt;

  crd_lane_sched #(.NUM_LANES(N), .iWIDTH(W), .ERR_THRESH(THRESH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .lane_valid(lane_valid), .lane_data(lane_data),
    .lane_ready(lane_ready), .lane_clr(lane_clr), .chk_valid(chk_valid),
    .chk_lane(chk_lane), .chk_err(chk_err), .crd_bit(crd_bit), .lane_fail(lane_fail),
    .err_cnt_sel(err_cnt_sel), .err_cnt(err_cnt)
  );

  crd_lane_sched #(.NUM_LANES(N), .iWIDTH(W), .ERR_THRESH(15), .CNT_WIDTH(2)) sat_dut (
    .clk(clk), .rst(rst), .lane_valid(s_valid), .lane_data(s_data),
    .lane_ready(s_ready), .lane_clr(s_clr), .chk_valid(s_chk_valid),
    .chk_lane(s_chk_lane), .chk_err(s_chk_err), .crd_bit(s_crd), .lane_fail(s_fail),
    .err_cnt_sel(s_sel), .err_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Lane model: RD is 0 idle, 1 negative, 2 positive.
  int           m_rd     [N];
  int           m_streak [N];
  int           m_cnt    [N];
  logic [N-1:0] m_fail;
  int           m_rr;
  bit           p_valid;
  lidx_t        p_lane;
  logic [W-1:0] p_data;
  bit           e_valid;
  lidx_t        e_lane;
  bit           e_err;
  bit           e_crd;
  logic [N-1:0] obs_ready;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      m_rd[i]     = 0;
      m_streak[i] = 0;
      m_cnt[i]    = 0;
    end
    m_fail  = '0;
    m_rr    = 0;
    p_valid = 1'b0;
    p_lane  = '0;
    p_data  = '0;
    e_valid = 1'b0;
    e_lane  = '0;
    e_err   = 1'b0;
    e_crd   = 1'b0;
  endtask

  function automatic int modelGrant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      lidx_t idx;
      idx = lidx_t'((m_rr + k) % N);
      if (v[idx] && !m_fail[idx]) return int'(idx);
    end
    return -1;
  endfunction

  task automatic modelEdge(input logic [N-1:0] v, input logic [N*W-1:0] d,
                           input logic [N-1:0] c, input int g);
    int ones;
    int cur;
    int nr;
    bit err;
    e_valid = 1'b0;
    if (p_valid && !c[p_lane]) begin
      ones = $countones(p_data);
      cur  = m_rd[p_lane];
      if (cur == 0) begin
        nr  = (ones >= W / 2) ? 2 : 1;
        err = 1'b0;
      end else if (ones == W / 2) begin
        nr  = cur;
        err = 1'b0;
      end else if (ones > W / 2) begin
        nr  = 2;
        err = (cur == 2);
      end else begin
        nr  = 1;
        err = (cur == 1);
      end
      e_valid = 1'b1;
      e_lane  = p_lane;
      e_err   = err;
      e_crd   = (nr == 2);
      if (err) begin
        m_streak[p_lane]++;
        if (m_cnt[p_lane] < (1 << CW) - 1) m_cnt[p_lane]++;
        if (m_streak[p_lane] >= THRESH) begin
          m_fail[p_lane] = 1'b1;
          nr = 0;
        end
      end else begin
        m_streak[p_lane] = 0;
      end
      m_rd[p_lane] = nr;
    end
    for (int i = 0; i < N; i++) begin
      if (c[i]) begin
        m_rd[i]     = 0;
        m_streak[i] = 0;
        m_cnt[i]    = 0;
        m_fail[i]   = 1'b0;
      end
    end
    if (g >= 0) begin
      p_valid = 1'b1;
      p_lane  = lidx_t'(g);
      p_data  = d[g*W +: W];
      m_rr    = (g + 1) % N;
    end else begin
      p_valid = 1'b0;
    end
  endtask

  // One clock: drive at edge+1, check grant at the falling edge, check results at edge+1.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [N*W-1:0] d,
                               input logic [N-1:0] c, input lidx_t sel, output int g);
    lane_valid  = v;
    lane_data   = d;
    lane_clr    = c;
    err_cnt_sel = sel;
    @(negedge clk);
    g         = modelGrant(v);
    obs_ready = lane_ready;
    checkOutput("lane_ready", lane_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
    checkOutput("lane_fail_pre", lane_fail, m_fail);
    checkOutput("err_cnt", err_cnt, m_cnt[sel]);
    @(posedge clk);
    modelEdge(v, d, c, g);
    #1;
    checkOutput("chk_valid", chk_valid, e_valid);
    checkOutput("chk_lane", chk_lane, e_lane);
    checkOutput("chk_err", chk_err, e_err);
    checkOutput("crd_bit", crd_bit, e_crd);
    checkOutput("lane_fail", lane_fail, m_fail);
  endtask

  task automatic doReset();
    rst         = 1'b0;
    lane_valid  = '0;
    lane_clr    = '0;
    err_cnt_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    checkOutput("rst_chk_valid", chk_valid, 0);
    checkOutput("rst_chk_lane", chk_lane, 0);
    checkOutput("rst_chk_err", chk_err, 0);
    checkOutput("rst_crd_bit", crd_bit, 0);
    checkOutput("rst_lane_fail", lane_fail, 0);
    checkOutput("rst_err_cnt", err_cnt, 0);
    rst = 1'b1;
  endtask

  function automatic logic [N*W-1:0] allData(input logic [W-1:0] sym);
    return {N{sym}};
  endfunction

  initial begin
    int g;
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    logic [N-1:0]   c;
    logic [W-1:0]   sym;

    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b0;
    lane_valid = '0;
    lane_data  = '0;
    lane_clr   = '0;
    s_valid    = '0;
    s_data     = '0;
    s_clr      = '0;
    s_sel      = '0;
    modelReset();
    #1;
    doReset();

    // First symbol after reset: 5 ones from IDLE goes positive.
    applyStimulus(4'b0001, allData(10'h3E0), '0, 2'd0, g);
    applyStimulus('0, allData('0), '0, 2'd0, g);
    checkOutput("t1_valid", chk_valid, 1);
    checkOutput("t1_lane", chk_lane, 0);
    checkOutput("t1_err", chk_err, 0);
    checkOutput("t1_crd", crd_bit, 1);
    checkOutput("t1_cnt", err_cnt, 0);

    // Lane 1: 0x3C0, 0x3C0, 0x3F0, 0x3F0 -> crd 0,0,1,1 and err 0,1,0,1.
    for (int k = 0; k < 5; k++) begin
      applyStimulus((k < 4) ? 4'b0010 : 4'b0000, allData((k < 2) ? 10'h3C0 : 10'h3F0),
                    '0, 2'd1, g);
      if (k >= 1) begin
        checkOutput("t2_crd", crd_bit, ((k - 1) >= 2) ? 1 : 0);
        checkOutput("t2_err", chk_err, ((k - 1) % 2 == 1) ? 1 : 0);
      end
    end
    checkOutput("t2_cnt", err_cnt, 2);

    // All lanes requesting: grants rotate 0..3, results lag by one call.
    doReset();
    for (int k = 0; k < 9; k++) begin
      applyStimulus((k < 8) ? 4'b1111 : 4'b0000, allData(10'h3E0), '0, lidx_t'(k % 4), g);
      if (k < 8) checkOutput("t3_grant", obs_ready, 32'd1 << (k % 4));
      if (k >= 1) begin
        checkOutput("t3_valid", chk_valid, 1);
        checkOutput("t3_chk_lane", chk_lane, (k - 1) % 4);
      end
    end

    // Lane 2 fails on its fourth consecutive error, is skipped, then recovers by clear.
    doReset();
    for (int k = 0; k < 5; k++) applyStimulus(4'b0100, allData(10'h3F0), '0, 2'd2, g);
    applyStimulus('0, allData(10'h3E0), '0, 2'd2, g);
    checkOutput("t4_fail", lane_fail[2], 1);
    checkOutput("t4_err", chk_err, 1);
    checkOutput("t4_lane", chk_lane, 2);
    checkOutput("t4_cnt", err_cnt, 4);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(4'b1111, allData(10'h3E0), '0, 2'd2, g);
      checkOutput("t4_ready2", obs_ready[2], 0);
      if (k >= 1) checkOutput("t4_served", chk_valid, 1);
    end
    applyStimulus('0, allData('0), 4'b0100, 2'd2, g);
    checkOutput("t4_clr_fail", lane_fail[2], 0);
    checkOutput("t4_clr_cnt", err_cnt, 0);
    applyStimulus(4'b0100, allData(10'h3C0), '0, 2'd2, g);
    applyStimulus('0, allData('0), '0, 2'd2, g);
    checkOutput("t4_post_valid", chk_valid, 1);
    checkOutput("t4_post_crd", crd_bit, 0);
    checkOutput("t4_post_err", chk_err, 0);

    // Clear of lane 3 while its symbol sits in stage 1 drops that result.
    applyStimulus(4'b1000, allData(10'h3E0), '0, 2'd3, g);
    applyStimulus(4'b1000, allData(10'h3F0), 4'b1000, 2'd3, g);
    checkOutput("t5_discard", chk_valid, 0);
    applyStimulus('0, allData('0), '0, 2'd3, g);
    checkOutput("t5_accept_valid", chk_valid, 1);
    checkOutput("t5_accept_err", chk_err, 0);
    checkOutput("t5_accept_crd", crd_bit, 1);

    // Reset while a lane is failed and stage 1 is full.
    for (int k = 0; k < 5; k++) applyStimulus(4'b0100, allData(10'h3F0), '0, 2'd2, g);
    applyStimulus(4'b0001, allData(10'h3E0), '0, 2'd2, g);
    checkOutput("t6_fail_set", lane_fail[2], 1);
    checkOutput("t6_valid_pre", chk_valid, 1);
    rst = 1'b0;
    #1;
    checkOutput("t6_rst_valid", chk_valid, 0);
    checkOutput("t6_rst_fail", lane_fail, 0);
    lane_valid = '0;
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t6_dropped", chk_valid, 0);

    // Random traffic, biased towards the three interesting symbol weights.
    for (int n = 0; n < 600; n++) begin
      v = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0:       sym = 10'h3E0;
          1:       sym = 10'h3C0;
          2:       sym = 10'h3F0;
          default: sym = 10'($urandom_range(0, 1023));
        endcase
        d[i*W +: W] = sym;
        c[i]        = ($urandom_range(0, 19) == 0);
      end
      applyStimulus(v, d, c, lidx_t'($urandom_range(0, 3)), g);
    end
    lane_valid = '0;
    lane_clr   = '0;

    // Two-bit counter, threshold 15: six errors must stick at 3.
    s_sel  = '0;
    s_data = allData(10'h3F0);
    for (int k = 0; k < 11; k++) begin
      s_valid = (k < 7) ? 4'b0001 : 4'b0000;
      @(posedge clk);
      #1;
    end
    checkOutput("sat_cnt", s_cnt, 3);
    checkOutput("sat_fail", s_fail, 0);
    checkOutput("sat_last_err", s_chk_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
